// File: rtl/block_merger.sv
// block_merger: scatters toggle-strobed pixels of M x M blocks into a raster-ordered frame memory.
// Define BLOCK_MERGER_CHECKSUM_EN to build the running checksum of written pixel data.
module block_merger #(
    parameter int Data_Depth = 8,
    parameter int Addr_Width = 19,
    parameter int Img_Size   = 720
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_valid,
    input  logic [7:0]            cfg_M,
    input  logic [Data_Depth-1:0] Pixel_Data,
    input  logic                  new_pixel,
    input  logic                  done_in,
    output logic                  mem_we,
    output logic [Addr_Width-1:0] mem_addr,
    output logic [Data_Depth-1:0] mem_data,
    output logic                  block_done,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  err_cfg,
    output logic                  err_overrun,
    output logic                  err_underrun,
    output logic [26:0]           frame_checksum
);
    localparam int PW  = Addr_Width + 8;
    localparam int BW  = 16;
    localparam int BW1 = BW + 1;
    localparam logic [PW-1:0] IMG_P = PW'(Img_Size);
    localparam logic [BW:0]   IMG_B = BW1'(Img_Size);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_new_pixel_d;
    logic                  r_done_d;
    logic [7:0]            r_m;
    logic [12:0]           r_mm;
    logic [7:0]            r_c;
    logic [7:0]            r_r;
    logic [12:0]           r_cnt;
    logic [BW-1:0]         r_col_base;
    logic [BW-1:0]         r_row_base;
    logic                  r_mem_we;
    logic [Addr_Width-1:0] r_mem_addr;
    logic [Data_Depth-1:0] r_mem_data;
    logic                  r_block_done;
    logic                  r_frame_done;
    logic                  r_busy;
    logic                  r_err_cfg;
    logic                  r_err_overrun;
    logic                  r_err_underrun;

    logic                  w_pix_stb;
    logic                  w_done_stb;
    logic                  w_cfg_ok;
    logic                  w_write;
    logic [12:0]           w_cnt_next;
    logic [Addr_Width-1:0] w_addr;
    logic [BW:0]           w_col_end;
    logic [BW:0]           w_row_end;
    logic                  w_col_wrap;
    logic                  w_last;

    assign w_pix_stb  = new_pixel ^ r_new_pixel_d;
    assign w_done_stb = done_in & ~r_done_d;
    assign w_cfg_ok   = (r_state == ST_IDLE) && cfg_valid && (cfg_M != 8'd0);
    assign w_write    = w_pix_stb && (r_state == ST_RUN) && (r_cnt < r_mm);
    // The pixel accepted in a done cycle counts toward the underrun check.
    assign w_cnt_next = r_cnt + {12'd0, w_write};
    assign w_addr     = Addr_Width'((PW'(r_row_base) + PW'(r_r)) * IMG_P
                                    + PW'(r_col_base) + PW'(r_c));
    assign w_col_end  = {1'b0, r_col_base} + {{(BW1-8){1'b0}}, r_m};
    assign w_row_end  = {1'b0, r_row_base} + {{(BW1-8){1'b0}}, r_m};
    assign w_col_wrap = (w_col_end >= IMG_B);
    assign w_last     = w_col_wrap && (w_row_end >= IMG_B);

    // Strobe history, tracked in every state so IDLE toggles are absorbed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_new_pixel_d <= 1'b0;
            r_done_d      <= 1'b0;
        end else begin
            r_new_pixel_d <= new_pixel;
            r_done_d      <= done_in;
        end
    end

    // Control FSM with block position counters and registered memory port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_m            <= 8'd0;
            r_mm           <= 13'd0;
            r_c            <= 8'd0;
            r_r            <= 8'd0;
            r_cnt          <= 13'd0;
            r_col_base     <= {BW{1'b0}};
            r_row_base     <= {BW{1'b0}};
            r_mem_we       <= 1'b0;
            r_mem_addr     <= {Addr_Width{1'b0}};
            r_mem_data     <= {Data_Depth{1'b0}};
            r_block_done   <= 1'b0;
            r_frame_done   <= 1'b0;
            r_busy         <= 1'b0;
            r_err_cfg      <= 1'b0;
            r_err_overrun  <= 1'b0;
            r_err_underrun <= 1'b0;
        end else begin
            r_mem_we     <= 1'b0;
            r_block_done <= 1'b0;
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_cfg_ok) begin
                        r_m        <= cfg_M;
                        r_mm       <= {5'd0, cfg_M} * {5'd0, cfg_M};
                        r_c        <= 8'd0;
                        r_r        <= 8'd0;
                        r_cnt      <= 13'd0;
                        r_col_base <= {BW{1'b0}};
                        r_row_base <= {BW{1'b0}};
                        r_err_cfg  <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= ST_RUN;
                    end else if (cfg_valid) begin
                        r_err_cfg <= 1'b1;
                    end
                end
                ST_RUN, ST_WAIT: begin
                    if (w_write) begin
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= w_addr;
                        r_mem_data <= Pixel_Data;
                        r_cnt      <= w_cnt_next;
                        if (r_c == r_m - 8'd1) begin
                            r_c <= 8'd0;
                            r_r <= r_r + 8'd1;
                        end else begin
                            r_c <= r_c + 8'd1;
                        end
                    end else if (w_pix_stb && (r_state == ST_WAIT)) begin
                        r_err_overrun <= 1'b1;
                    end

                    // Block end overrides the counter updates above.
                    if (w_done_stb) begin
                        if (w_cnt_next < r_mm) begin
                            r_err_underrun <= 1'b1;
                        end
                        r_block_done <= 1'b1;
                        r_c          <= 8'd0;
                        r_r          <= 8'd0;
                        r_cnt        <= 13'd0;
                        if (w_col_wrap) begin
                            r_col_base <= {BW{1'b0}};
                            r_row_base <= r_row_base + {{(BW-8){1'b0}}, r_m};
                        end else begin
                            r_col_base <= r_col_base + {{(BW-8){1'b0}}, r_m};
                        end
                        if (w_last) begin
                            r_frame_done <= 1'b1;
                            r_busy       <= 1'b0;
                            r_state      <= ST_IDLE;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end else if (w_write && (w_cnt_next == r_mm)) begin
                        r_state <= ST_WAIT;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef BLOCK_MERGER_CHECKSUM_EN
    logic [26:0] r_checksum;

    // Running sum of written pixels; no writes occur in IDLE, so it holds after frame_done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_checksum <= 27'd0;
        end else if (w_cfg_ok) begin
            r_checksum <= 27'd0;
        end else if (w_write) begin
            r_checksum <= r_checksum + 27'(Pixel_Data);
        end
    end

    assign frame_checksum = r_checksum;
`else
    assign frame_checksum = 27'd0;
`endif

    assign mem_we       = r_mem_we;
    assign mem_addr     = r_mem_addr;
    assign mem_data     = r_mem_data;
    assign block_done   = r_block_done;
    assign frame_done   = r_frame_done;
    assign busy         = r_busy;
    assign err_cfg      = r_err_cfg;
    assign err_overrun  = r_err_overrun;
    assign err_underrun = r_err_underrun;

endmodule

// File: tb/tb_block_merger.sv
// Directed self-checking bench for block_merger on a 4x4 image.
module tb_block_merger;
    localparam int DD  = 8;
    localparam int AW  = 19;
    localparam int IMG = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_valid = 1'b0;
    logic [7:0]    cfg_M = 8'd0;
    logic [DD-1:0] Pixel_Data = 8'd0;
    logic          new_pixel = 1'b0;
    logic          done_in = 1'b0;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DD-1:0] mem_data;
    logic          block_done;
    logic          frame_done;
    logic          busy;
    logic          err_cfg;
    logic          err_overrun;
    logic          err_underrun;
    logic [26:0]   frame_checksum;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_cnt = 0;
    int bd_cnt = 0;
    int exp_a [16] = '{0, 1, 4, 5, 2, 3, 6, 7, 8, 9, 12, 13, 10, 11, 14, 15};

    block_merger #(.Data_Depth(DD), .Addr_Width(AW), .Img_Size(IMG)) dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_M(cfg_M),
        .Pixel_Data(Pixel_Data), .new_pixel(new_pixel), .done_in(done_in),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_data(mem_data),
        .block_done(block_done), .frame_done(frame_done), .busy(busy),
        .err_cfg(err_cfg), .err_overrun(err_overrun), .err_underrun(err_underrun),
        .frame_checksum(frame_checksum)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we) wr_cnt <= wr_cnt + 1;
        if (block_done) bd_cnt <= bd_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic [7:0] d);
        Pixel_Data = d;
        new_pixel  = ~new_pixel;
        step();
    endtask

    task automatic do_cfg(input logic [7:0] m);
        cfg_M     = m;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_reset();
        step();
        step();
        n_cmp++;
        if ({mem_we, block_done, frame_done, busy, err_cfg, err_overrun, err_underrun} !== 7'd0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, required 0000000",
                     {mem_we, block_done, frame_done, busy, err_cfg, err_overrun, err_underrun});
        end
        n_cmp++;
        if (mem_addr !== 19'd0 || mem_data !== 8'd0) begin
            n_bad++;
            $display("FAIL reset_port: addr=%0d data=%0d, required 0 0", mem_addr, mem_data);
        end
        n_cmp++;
        if (frame_checksum !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_cksum: got %0d, required 0", frame_checksum);
        end
        rst = 1'b0;
        step();
    endtask

    task automatic test_frame();
        int bd0;
        logic [26:0] exp_ck;
        logic fd_exp;
        bd0 = bd_cnt;
        do_cfg(8'd2);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_busy: got %b, required 1", busy);
        end
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 4; k++) begin
                pix(8'(4 * b + k + 1));
                n_cmp++;
                if (mem_we !== 1'b1 || mem_addr !== 19'(exp_a[4 * b + k]) || mem_data !== 8'(4 * b + k + 1)) begin
                    n_bad++;
                    $display("FAIL frame_write[%0d]: we=%b addr=%0d data=%0d, required we=1 addr=%0d data=%0d",
                             4 * b + k, mem_we, mem_addr, mem_data, exp_a[4 * b + k], 4 * b + k + 1);
                end
            end
            done_in = 1'b1;
            step();
            fd_exp = (b == 3);
            n_cmp++;
            if (block_done !== 1'b1 || frame_done !== fd_exp) begin
                n_bad++;
                $display("FAIL frame_done[%0d]: block_done=%b frame_done=%b, required 1 %b",
                         b, block_done, frame_done, fd_exp);
            end
            done_in = 1'b0;
            step();
        end
        n_cmp++;
        if (bd_cnt - bd0 != 4 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL frame_end: block_done count=%0d busy=%b, required 4 0", bd_cnt - bd0, busy);
        end
`ifdef BLOCK_MERGER_CHECKSUM_EN
        exp_ck = 27'd136;
`else
        exp_ck = 27'd0;
`endif
        n_cmp++;
        if (frame_checksum !== exp_ck) begin
            n_bad++;
            $display("FAIL frame_cksum: got %0d, required %0d", frame_checksum, exp_ck);
        end
    endtask

    task automatic test_cfg_err();
        logic [26:0] exp_ck;
        do_cfg(8'd0);
        n_cmp++;
        if (err_cfg !== 1'b1 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL cfg_zero: err_cfg=%b busy=%b, required 1 0", err_cfg, busy);
        end
        do_cfg(8'd4);
        n_cmp++;
        if (err_cfg !== 1'b0 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL cfg_four: err_cfg=%b busy=%b, required 0 1", err_cfg, busy);
        end
        for (int i = 0; i < 16; i++) begin
            pix(8'(i));
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== 19'(i) || mem_data !== 8'(i)) begin
                n_bad++;
                $display("FAIL m4_write[%0d]: we=%b addr=%0d data=%0d, required we=1 addr=%0d data=%0d",
                         i, mem_we, mem_addr, mem_data, i, i);
            end
        end
        done_in = 1'b1;
        step();
        n_cmp++;
        if (block_done !== 1'b1 || frame_done !== 1'b1) begin
            n_bad++;
            $display("FAIL m4_done: block_done=%b frame_done=%b, required 1 1", block_done, frame_done);
        end
        done_in = 1'b0;
        step();
`ifdef BLOCK_MERGER_CHECKSUM_EN
        exp_ck = 27'd120;
`else
        exp_ck = 27'd0;
`endif
        n_cmp++;
        if (frame_checksum !== exp_ck) begin
            n_bad++;
            $display("FAIL m4_cksum: got %0d, required %0d", frame_checksum, exp_ck);
        end
    endtask

    task automatic test_overrun();
        int w0;
        int bd0;
        do_cfg(8'd2);
        w0  = wr_cnt;
        bd0 = bd_cnt;
        for (int i = 0; i < 4; i++) begin
            pix(8'(i + 1));
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== 19'(exp_a[i])) begin
                n_bad++;
                $display("FAIL ovr_write[%0d]: we=%b addr=%0d, required 1 %0d", i, mem_we, mem_addr, exp_a[i]);
            end
        end
        pix(8'd9);
        n_cmp++;
        if (mem_we !== 1'b0 || err_overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL ovr_extra: we=%b err_overrun=%b, required 0 1", mem_we, err_overrun);
        end
        done_in = 1'b1;
        step();
        n_cmp++;
        if (block_done !== 1'b1 || err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_done: block_done=%b err_underrun=%b, required 1 0", block_done, err_underrun);
        end
        done_in = 1'b0;
        step();
        n_cmp++;
        if (wr_cnt - w0 != 4 || bd_cnt - bd0 != 1) begin
            n_bad++;
            $display("FAIL ovr_counts: writes=%0d block_done=%0d, required 4 1", wr_cnt - w0, bd_cnt - bd0);
        end
    endtask

    task automatic test_underrun();
        int w0;
        do_rst();
        do_cfg(8'd2);
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            pix(8'(i + 20));
            n_cmp++;
            if (mem_we !== 1'b1 || mem_addr !== 19'(exp_a[i])) begin
                n_bad++;
                $display("FAIL udr_write[%0d]: we=%b addr=%0d, required 1 %0d", i, mem_we, mem_addr, exp_a[i]);
            end
        end
        done_in = 1'b1;
        step();
        n_cmp++;
        if (block_done !== 1'b1 || err_underrun !== 1'b1) begin
            n_bad++;
            $display("FAIL udr_done: block_done=%b err_underrun=%b, required 1 1", block_done, err_underrun);
        end
        done_in = 1'b0;
        step();
        n_cmp++;
        if (wr_cnt - w0 != 3) begin
            n_bad++;
            $display("FAIL udr_count: writes=%0d, required 3", wr_cnt - w0);
        end
        pix(8'd30);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 19'd2) begin
            n_bad++;
            $display("FAIL udr_next: we=%b addr=%0d, required 1 2", mem_we, mem_addr);
        end
    endtask

    task automatic test_rst_mid();
        int w0;
        do_rst();
        do_cfg(8'd2);
        pix(8'd11);
        pix(8'd12);
        rst = 1'b1;
        #1;
        n_cmp++;
        if (mem_we !== 1'b0 || busy !== 1'b0 || mem_addr !== 19'd0 || mem_data !== 8'd0) begin
            n_bad++;
            $display("FAIL rst_mid: we=%b busy=%b addr=%0d data=%0d, required 0 0 0 0",
                     mem_we, busy, mem_addr, mem_data);
        end
        step();
        rst = 1'b0;
        w0 = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            pix(8'(i + 40));
        end
        step();
        n_cmp++;
        if (wr_cnt != w0 || mem_we !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle_writes: writes=%0d we=%b, required 0 0", wr_cnt - w0, mem_we);
        end
        do_cfg(8'd2);
        pix(8'd50);
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 19'd0 || mem_data !== 8'd50) begin
            n_bad++;
            $display("FAIL rst_first: we=%b addr=%0d data=%0d, required 1 0 50", mem_we, mem_addr, mem_data);
        end
    endtask

    task automatic test_simultaneous();
        int w0;
        int bd0;
        do_rst();
        do_cfg(8'd2);
        w0  = wr_cnt;
        bd0 = bd_cnt;
        for (int i = 0; i < 3; i++) begin
            pix(8'(i + 1));
        end
        Pixel_Data = 8'd4;
        new_pixel  = ~new_pixel;
        done_in    = 1'b1;
        step();
        n_cmp++;
        if (mem_we !== 1'b1 || mem_addr !== 19'd5 || mem_data !== 8'd4 ||
            block_done !== 1'b1 || err_underrun !== 1'b0) begin
            n_bad++;
            $display("FAIL sim_edge: we=%b addr=%0d data=%0d bd=%b udr=%b, required 1 5 4 1 0",
                     mem_we, mem_addr, mem_data, block_done, err_underrun);
        end
        done_in = 1'b0;
        step();
        n_cmp++;
        if (wr_cnt - w0 != 4 || bd_cnt - bd0 != 1) begin
            n_bad++;
            $display("FAIL sim_counts: writes=%0d block_done=%0d, required 4 1", wr_cnt - w0, bd_cnt - bd0);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_cfg_err();
        test_overrun();
        test_underrun();
        test_rst_mid();
        test_simultaneous();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/block_merger.md
Name: block_merger

Overview:
- Downstream stage of the block divider/watermark combiner.
- Consumes the combined pixels, which arrive one per toggle of the `new_pixel` line, plus the per-block `done` indication.
- Scatters the pixels into a raster-ordered frame memory through a simple write port.
- Tracks block position across the Img_Size x Img_Size image, flags protocol errors, and signals block and frame completion.

Parameters:
- Data_Depth, 8, pixel width in bits.
- Addr_Width, 19, frame-memory address width (720*720 = 518400 locations).
- Img_Size, 720, image side length in pixels. Must be a multiple of every M used; the bench overrides it to 4.

Ports:
- clk  input  1  system clock.
- rst  input  1  reset. The block uses one clock; reset is asynchronous and active-high.
- cfg_valid  input  1  one-cycle strobe; latches cfg_M. Honoured only in IDLE.
- cfg_M  input  8  block side M in pixels.
- Pixel_Data  input  Data_Depth  combined pixel; valid when new_pixel toggles.
- new_pixel  input  1  toggle strobe; each level change carries one pixel.
- done_in  input  1  upstream block-complete level; its rising edge ends a block.
- mem_we  output  1  frame-memory write enable, single-cycle pulse.
- mem_addr  output  Addr_Width  write address, row*Img_Size + col.
- mem_data  output  Data_Depth  write data.
- block_done  output  1  one-cycle pulse per merged block.
- frame_done  output  1  one-cycle pulse after the last block of the frame.
- busy  output  1  high in every state except IDLE.
- err_cfg  output  1  sticky; set by cfg_M == 0. Cleared by rst or the next valid cfg.
- err_overrun  output  1  sticky; more than M*M toggles in one block.
- err_underrun  output  1  sticky; done_in rose before M*M pixels.
- frame_checksum  output  27  see Optional Feature.

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0; new_pixel and done_in history registers 0.
- Edge detection:
  - Registers hold new_pixel_d and done_d.
  - pix_stb = new_pixel ^ new_pixel_d.
  - done_stb = done_in & ~done_d.
  - History registers update every cycle in all states. Toggles seen in IDLE are ignored; they never produce writes.
- Counters:
  - c, r: column and row within the block, 0..M-1.
  - col_base, row_base: image pixel coordinates of the block origin.
  - cnt: pixels received in the block, 0..M*M.
- Address: mem_addr = (row_base + r)*Img_Size + col_base + c, computed from registered values and truncated to Addr_Width.
- IDLE:
  - cfg_valid with cfg_M != 0: latch M, clear counters, bases and checksum, clear err_cfg, go to RUN.
  - cfg_valid with cfg_M == 0: set err_cfg, stay in IDLE.
- RUN:
  - On pix_stb with cnt < M*M: register Pixel_Data to mem_data and the address to mem_addr, assert mem_we for exactly one cycle. Latency is 1 cycle from the edge where pix_stb is true.
  - After each write: c++. When c == M-1, wrap c to 0 and increment r. cnt++.
  - When cnt reaches M*M, go to WAIT_DONE.
- WAIT_DONE:
  - A further pix_stb sets err_overrun; no write is issued and data is discarded.
- done_stb (in RUN or WAIT_DONE):
  - If cnt < M*M, set err_underrun; missing locations stay unwritten.
  - Pulse block_done, clear c, r and cnt.
  - Advance: col_base += M. If col_base + M >= Img_Size, set col_base = 0 and row_base += M.
  - If that was the last block (row_base + M >= Img_Size and col_base + M >= Img_Size): pulse frame_done in the same cycle as block_done, go to IDLE. Otherwise stay in RUN.
- Simultaneous pix_stb and done_stb: the pixel is written first, and cnt for the underrun check includes that pixel.
- cfg_valid outside IDLE is ignored.
- Async rst mid-frame: return immediately to reset values. Any pending write is dropped.
- Arithmetic: M*M is computed at 13 bits. Address products use Addr_Width+8 bits before truncation.

Optional Feature:
- Macro BLOCK_MERGER_CHECKSUM_EN.
- When defined:
  - frame_checksum accumulates the unsigned sum of every written mem_data (27 bits, wraps on overflow).
  - It is cleared on accepted cfg and holds its final value from the frame_done cycle until the next accepted cfg.
- When undefined: the accumulator is not built and frame_checksum is tied to 0.

Test Plan:
- Bench parameter: Img_Size=4.
- Config M=2, feed 4 blocks of pixels 1..16 in block order, done after each block:
  - Writes hit addresses 0,1,4,5 | 2,3,6,7 | 8,9,12,13 | 10,11,14,15.
  - 4 block_done pulses; frame_done coincides with the 4th block_done.
  - Checksum 136 with BLOCK_MERGER_CHECKSUM_EN defined, 0 without.
- cfg_M=0 -> err_cfg=1, busy=0. Then cfg_M=4 -> err_cfg=0, busy=1; 16 pixels 0..15 land at addresses 0..15.
- M=2: send 5 toggles, then done -> 4 writes, err_overrun=1, block_done pulses once.
- M=2: send 3 toggles, then done -> 3 writes, err_underrun=1; the next block starts at address 2.
- M=2: assert rst after 2 pixels -> all outputs 0 immediately; no mem_we while idle; after a new cfg, the first write is to address 0.
- M=2: the 4th toggle arrives in the same cycle as the done rising edge -> 4 writes, no err_underrun, block_done pulses once.
